// File: rtl/wb_pkg.sv
// Shared types for the register-file write arbiter.
// Holds register index sizes, the write request bundle and source select.
package wb_pkg;

   localparam int REG_IDX_W = 5;
   localparam int NUM_REGS  = 32;
   localparam int WB_DATA_W = 32;

   typedef struct packed {
      logic [REG_IDX_W-1:0] dst;
      logic [WB_DATA_W-1:0] data;
   } wb_req_t;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_PIPE,
      SRC_FIFO
   } wb_src_e;

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Long-latency result handshake (valid/ready) into the write arbiter.
// The producer uses master, the arbiter uses slave.
interface wb_write_arbiter_if #(
   parameter int DATA_W = 32
) ();

   logic              lu_valid;
   logic [4:0]        lu_reg;
   logic [DATA_W-1:0] lu_data;
   logic              lu_ready;

   modport master (
      output lu_valid,
      output lu_reg,
      output lu_data,
      input  lu_ready
   );

   modport slave (
      input  lu_valid,
      input  lu_reg,
      input  lu_data,
      output lu_ready
   );

endinterface

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO of pending long-latency writeback requests.
// Supports same-cycle push and pop; pointers wrap modulo DEPTH.
module wb_result_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  logic    pop,
   input  wb_req_t din,
   output wb_req_t dout,
   output logic    full,
   output logic    empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   wb_req_t       mem [DEPTH];
   logic [PW-1:0] wp;
   logic [PW-1:0] rp;
   logic [PW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt == FULL_CNT);
   assign empty   = (cnt == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rp];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wp] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop)  rp <= rp + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/wb_write_arbiter.sv
// Single writer of the register file: pipeline writeback beats FIFO results.
// Tracks pending long-latency writes; WB_FWD_EN adds read-during-write bypass.
module wb_write_arbiter
   import wb_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int DATA_W     = WB_DATA_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pipe_wr_en,
   input  logic [REG_IDX_W-1:0] pipe_wr_reg,
   input  logic [DATA_W-1:0]    pipe_wr_data,
   input  logic                 issue_valid,
   input  logic [REG_IDX_W-1:0] issue_reg,
   wb_write_arbiter_if.slave    lu,
   input  logic [REG_IDX_W-1:0] rd_reg1,
   input  logic [REG_IDX_W-1:0] rd_reg2,
   output logic                 hazard,
   output logic [NUM_REGS-1:0]  busy_mask,
`ifdef WB_FWD_EN
   output logic                 fwd_hit1,
   output logic                 fwd_hit2,
   output logic [DATA_W-1:0]    fwd_data1,
   output logic [DATA_W-1:0]    fwd_data2,
`endif
   output logic                 regWrite,
   output logic [REG_IDX_W-1:0] W_reg,
   output logic [DATA_W-1:0]    W_data
);

   wb_req_t             fifo_din;
   wb_req_t             head;
   logic                full;
   logic                empty;
   logic                push;
   logic                pop;
   logic                pipe_req;
   logic                from_fifo;
   wb_src_e             src;
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_nxt;

   assign lu.lu_ready   = ~full & ~rst;
   assign push          = lu.lu_valid & lu.lu_ready;
   assign fifo_din.dst  = lu.lu_reg;
   assign fifo_din.data = WB_DATA_W'(lu.lu_data);
   assign pipe_req      = pipe_wr_en & (pipe_wr_reg != '0);
   assign pop           = (src == SRC_FIFO);
   assign busy_mask     = busy;

   wb_result_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (fifo_din),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      src = SRC_NONE;
      priority case (1'b1)
         pipe_req: src = SRC_PIPE;
         !empty:   src = SRC_FIFO;
         default:  src = SRC_NONE;
      endcase
   end

   // A popped entry for r0 still drains but never asserts regWrite.
   always_ff @(posedge clk) begin
      if (rst) begin
         regWrite  <= 1'b0;
         W_reg     <= '0;
         W_data    <= '0;
         from_fifo <= 1'b0;
      end else begin
         unique case (src)
            SRC_PIPE: begin
               regWrite  <= 1'b1;
               W_reg     <= pipe_wr_reg;
               W_data    <= pipe_wr_data;
               from_fifo <= 1'b0;
            end
            SRC_FIFO: begin
               regWrite  <= (head.dst != '0);
               W_reg     <= head.dst;
               W_data    <= DATA_W'(head.data);
               from_fifo <= 1'b1;
            end
            default: begin
               regWrite  <= 1'b0;
               from_fifo <= 1'b0;
            end
         endcase
      end
   end

   // Clear on the commit edge; a same-cycle issue to that reg re-sets it.
   always_comb begin
      busy_nxt = busy;
      if (regWrite && from_fifo)
         busy_nxt[W_reg] = 1'b0;
      if (issue_valid && (issue_reg != '0))
         busy_nxt[issue_reg] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) busy <= '0;
      else     busy <= busy_nxt;
   end

`ifdef WB_FWD_EN
   assign fwd_hit1  = regWrite & (W_reg == rd_reg1)
                    & (W_reg != '0);
   assign fwd_hit2  = regWrite & (W_reg == rd_reg2)
                    & (W_reg != '0);
   assign fwd_data1 = W_data;
   assign fwd_data2 = W_data;
   assign hazard    = (busy[rd_reg1] & ~fwd_hit1)
                    | (busy[rd_reg2] & ~fwd_hit2);
`else
   assign hazard = busy[rd_reg1] | busy[rd_reg2];
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed testbench for wb_write_arbiter.
// Build with WB_FWD_EN defined to also cover the bypass outputs.
module tb_wb_write_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_wr_en;
   logic [4:0]  pipe_wr_reg;
   logic [31:0] pipe_wr_data;
   logic        issue_valid;
   logic [4:0]  issue_reg;
   logic [4:0]  rd_reg1;
   logic [4:0]  rd_reg2;
   logic        hazard;
   logic [31:0] busy_mask;
   logic        regWrite;
   logic [4:0]  W_reg;
   logic [31:0] W_data;
`ifdef WB_FWD_EN
   logic        fwd_hit1;
   logic        fwd_hit2;
   logic [31:0] fwd_data1;
   logic [31:0] fwd_data2;
`endif

   int tests = 0;
   int fails = 0;

   wb_write_arbiter_if #(.DATA_W(32)) lu_if ();

   wb_write_arbiter #(
      .FIFO_DEPTH (2),
      .DATA_W     (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pipe_wr_en   (pipe_wr_en),
      .pipe_wr_reg  (pipe_wr_reg),
      .pipe_wr_data (pipe_wr_data),
      .issue_valid  (issue_valid),
      .issue_reg    (issue_reg),
      .lu           (lu_if.slave),
      .rd_reg1      (rd_reg1),
      .rd_reg2      (rd_reg2),
      .hazard       (hazard),
      .busy_mask    (busy_mask),
`ifdef WB_FWD_EN
      .fwd_hit1     (fwd_hit1),
      .fwd_hit2     (fwd_hit2),
      .fwd_data1    (fwd_data1),
      .fwd_data2    (fwd_data2),
`endif
      .regWrite     (regWrite),
      .W_reg        (W_reg),
      .W_data       (W_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      lu_if.lu_valid = 1'b1;
      lu_if.lu_reg = 5'd6;
      lu_if.lu_data = 32'h66;
      tick();
      tick();
      tests++;
      if (lu_if.lu_ready !== 1'b0) begin
         fails++;
         $display("FAIL rst_ready got=%b exp=0", lu_if.lu_ready);
      end
      tests++;
      if (regWrite !== 1'b0) begin
         fails++;
         $display("FAIL rst_regwrite got=%b exp=0", regWrite);
      end
      tests++;
      if (busy_mask !== 32'h0) begin
         fails++;
         $display("FAIL rst_busy got=%h exp=0", busy_mask);
      end
      tests++;
      if (W_reg !== 5'd0 || W_data !== 32'h0) begin
         fails++;
         $display("FAIL rst_wout got=%0d/%h exp=0/0", W_reg, W_data);
      end
      lu_if.lu_valid = 1'b0;
      rst = 1'b0;
      #1;
      tests++;
      if (lu_if.lu_ready !== 1'b1) begin
         fails++;
         $display("FAIL rel_ready got=%b exp=1", lu_if.lu_ready);
      end
      tick();
      tests++;
      if (regWrite !== 1'b0) begin
         fails++;
         $display("FAIL rel_regwrite got=%b exp=0", regWrite);
      end
   endtask

   task automatic test_pipe();
      pipe_wr_en = 1'b1;
      pipe_wr_reg = 5'd5;
      pipe_wr_data = 32'hDEADBEEF;
      tick();
      tests++;
      if (regWrite !== 1'b1 || W_reg !== 5'd5
          || W_data !== 32'hDEADBEEF) begin
         fails++;
         $display("FAIL pipe_wr got=%b/%0d/%h exp=1/5/deadbeef",
                  regWrite, W_reg, W_data);
      end
      pipe_wr_reg = 5'd0;
      pipe_wr_data = 32'h1234;
      tick();
      tests++;
      if (regWrite !== 1'b0 || W_reg !== 5'd5
          || W_data !== 32'hDEADBEEF) begin
         fails++;
         $display("FAIL pipe_r0 got=%b/%0d/%h exp=0/5/deadbeef",
                  regWrite, W_reg, W_data);
      end
      pipe_wr_en = 1'b0;
   endtask

   task automatic test_scoreboard();
      issue_valid = 1'b1;
      issue_reg = 5'd9;
      tick();
      issue_valid = 1'b0;
      tests++;
      if (busy_mask !== 32'h200) begin
         fails++;
         $display("FAIL sb_set got=%h exp=200", busy_mask);
      end
      rd_reg1 = 5'd9;
      #1;
      tests++;
      if (hazard !== 1'b1) begin
         fails++;
         $display("FAIL sb_haz got=%b exp=1", hazard);
      end
      rd_reg1 = 5'd3;
      #1;
      tests++;
      if (hazard !== 1'b0) begin
         fails++;
         $display("FAIL sb_nohaz got=%b exp=0", hazard);
      end
      lu_if.lu_valid = 1'b1;
      lu_if.lu_reg = 5'd9;
      lu_if.lu_data = 32'h42;
      tick();
      lu_if.lu_valid = 1'b0;
      tests++;
      if (regWrite !== 1'b0) begin
         fails++;
         $display("FAIL sb_lat1 got=%b exp=0", regWrite);
      end
      tick();
      tests++;
      if (regWrite !== 1'b1 || W_reg !== 5'd9
          || W_data !== 32'h42) begin
         fails++;
         $display("FAIL sb_commit got=%b/%0d/%h exp=1/9/42",
                  regWrite, W_reg, W_data);
      end
      tests++;
      if (busy_mask !== 32'h200) begin
         fails++;
         $display("FAIL sb_hold got=%h exp=200", busy_mask);
      end
      tick();
      tests++;
      if (busy_mask !== 32'h0 || regWrite !== 1'b0) begin
         fails++;
         $display("FAIL sb_clear got=%h/%b exp=0/0",
                  busy_mask, regWrite);
      end
      rd_reg1 = 5'd0;
   endtask

   task automatic test_fill_drain();
      pipe_wr_en = 1'b1;
      pipe_wr_reg = 5'd1;
      pipe_wr_data = 32'h11;
      lu_if.lu_valid = 1'b1;
      lu_if.lu_reg = 5'd3;
      lu_if.lu_data = 32'h33;
      tick();
      lu_if.lu_reg = 5'd4;
      lu_if.lu_data = 32'h44;
      tick();
      lu_if.lu_valid = 1'b0;
      tests++;
      if (lu_if.lu_ready !== 1'b0) begin
         fails++;
         $display("FAIL fd_full got=%b exp=0", lu_if.lu_ready);
      end
      tick();
      tests++;
      if (regWrite !== 1'b1 || W_reg !== 5'd1
          || lu_if.lu_ready !== 1'b0) begin
         fails++;
         $display("FAIL fd_starve got=%b/%0d/%b exp=1/1/0",
                  regWrite, W_reg, lu_if.lu_ready);
      end
      pipe_wr_en = 1'b0;
      tick();
      tests++;
      if (regWrite !== 1'b1 || W_reg !== 5'd3
          || W_data !== 32'h33) begin
         fails++;
         $display("FAIL fd_first got=%b/%0d/%h exp=1/3/33",
                  regWrite, W_reg, W_data);
      end
      tests++;
      if (lu_if.lu_ready !== 1'b1) begin
         fails++;
         $display("FAIL fd_ready got=%b exp=1", lu_if.lu_ready);
      end
      tick();
      tests++;
      if (regWrite !== 1'b1 || W_reg !== 5'd4
          || W_data !== 32'h44) begin
         fails++;
         $display("FAIL fd_second got=%b/%0d/%h exp=1/4/44",
                  regWrite, W_reg, W_data);
      end
      tick();
      tests++;
      if (regWrite !== 1'b0) begin
         fails++;
         $display("FAIL fd_idle got=%b exp=0", regWrite);
      end
   endtask

   task automatic test_set_wins();
      issue_valid = 1'b1;
      issue_reg = 5'd7;
      tick();
      issue_valid = 1'b0;
      lu_if.lu_valid = 1'b1;
      lu_if.lu_reg = 5'd7;
      lu_if.lu_data = 32'h77;
      tick();
      lu_if.lu_valid = 1'b0;
      tick();
      tests++;
      if (regWrite !== 1'b1 || W_reg !== 5'd7) begin
         fails++;
         $display("FAIL sw_commit got=%b/%0d exp=1/7",
                  regWrite, W_reg);
      end
      issue_valid = 1'b1;
      issue_reg = 5'd7;
      tick();
      issue_valid = 1'b0;
      tests++;
      if (busy_mask !== 32'h80) begin
         fails++;
         $display("FAIL sw_setwins got=%h exp=80", busy_mask);
      end
      lu_if.lu_valid = 1'b1;
      tick();
      lu_if.lu_valid = 1'b0;
      tick();
      tick();
      tests++;
      if (busy_mask !== 32'h0) begin
         fails++;
         $display("FAIL sw_clear got=%h exp=0", busy_mask);
      end
   endtask

   task automatic test_waw();
      issue_valid = 1'b1;
      issue_reg = 5'd13;
      tick();
      issue_valid = 1'b0;
      pipe_wr_en = 1'b1;
      pipe_wr_reg = 5'd13;
      pipe_wr_data = 32'h99;
      tick();
      pipe_wr_en = 1'b0;
      rd_reg1 = 5'd13;
      #1;
      tests++;
      if (regWrite !== 1'b1 || W_reg !== 5'd13
          || busy_mask !== 32'h2000) begin
         fails++;
         $display("FAIL waw got=%b/%0d/%h exp=1/13/2000",
                  regWrite, W_reg, busy_mask);
      end
      tests++;
`ifdef WB_FWD_EN
      if (hazard !== 1'b0) begin
         fails++;
         $display("FAIL waw_haz got=%b exp=0", hazard);
      end
`else
      if (hazard !== 1'b1) begin
         fails++;
         $display("FAIL waw_haz got=%b exp=1", hazard);
      end
`endif
      rd_reg1 = 5'd0;
      lu_if.lu_valid = 1'b1;
      lu_if.lu_reg = 5'd13;
      lu_if.lu_data = 32'h9A;
      tick();
      lu_if.lu_valid = 1'b0;
      tick();
      tick();
      tests++;
      if (busy_mask !== 32'h0) begin
         fails++;
         $display("FAIL waw_clear got=%h exp=0", busy_mask);
      end
   endtask

   task automatic test_fifo_r0();
      lu_if.lu_valid = 1'b1;
      lu_if.lu_reg = 5'd0;
      lu_if.lu_data = 32'h5;
      tick();
      lu_if.lu_valid = 1'b0;
      tick();
      tests++;
      if (regWrite !== 1'b0 || lu_if.lu_ready !== 1'b1) begin
         fails++;
         $display("FAIL fifo_r0 got=%b/%b exp=0/1",
                  regWrite, lu_if.lu_ready);
      end
      tick();
      tests++;
      if (regWrite !== 1'b0) begin
         fails++;
         $display("FAIL fifo_r0_drained got=%b exp=0", regWrite);
      end
   endtask

   task automatic test_mid_reset();
      issue_valid = 1'b1;
      issue_reg = 5'd10;
      lu_if.lu_valid = 1'b1;
      lu_if.lu_reg = 5'd10;
      lu_if.lu_data = 32'hA0;
      pipe_wr_en = 1'b1;
      pipe_wr_reg = 5'd2;
      pipe_wr_data = 32'h22;
      tick();
      issue_valid = 1'b0;
      lu_if.lu_valid = 1'b0;
      rst = 1'b1;
      pipe_wr_en = 1'b0;
      tick();
      tests++;
      if (busy_mask !== 32'h0 || regWrite !== 1'b0
          || W_reg !== 5'd0) begin
         fails++;
         $display("FAIL mrst got=%h/%b/%0d exp=0/0/0",
                  busy_mask, regWrite, W_reg);
      end
      rst = 1'b0;
      tick();
      tick();
      tests++;
      if (regWrite !== 1'b0 || lu_if.lu_ready !== 1'b1) begin
         fails++;
         $display("FAIL mrst_flush got=%b/%b exp=0/1",
                  regWrite, lu_if.lu_ready);
      end
   endtask

`ifdef WB_FWD_EN
   task automatic test_fwd();
      pipe_wr_en = 1'b1;
      pipe_wr_reg = 5'd12;
      pipe_wr_data = 32'h55;
      tick();
      pipe_wr_en = 1'b0;
      rd_reg1 = 5'd3;
      rd_reg2 = 5'd12;
      #1;
      tests++;
      if (fwd_hit2 !== 1'b1 || fwd_data2 !== 32'h55) begin
         fails++;
         $display("FAIL fwd_hit2 got=%b/%h exp=1/55",
                  fwd_hit2, fwd_data2);
      end
      tests++;
      if (fwd_hit1 !== 1'b0) begin
         fails++;
         $display("FAIL fwd_miss1 got=%b exp=0", fwd_hit1);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rd_reg2 = 5'd0;
      #1;
      tests++;
      if (fwd_hit2 !== 1'b0) begin
         fails++;
         $display("FAIL fwd_r0 got=%b exp=0", fwd_hit2);
      end
      rd_reg1 = 5'd0;
   endtask
`endif

   initial begin
      rst = 1'b1;
      pipe_wr_en = 1'b0;
      pipe_wr_reg = '0;
      pipe_wr_data = '0;
      issue_valid = 1'b0;
      issue_reg = '0;
      rd_reg1 = '0;
      rd_reg2 = '0;
      lu_if.lu_valid = 1'b0;
      lu_if.lu_reg = '0;
      lu_if.lu_data = '0;
      test_reset();
      test_pipe();
      test_scoreboard();
      test_fill_drain();
      test_set_wins();
      test_waw();
      test_fifo_r0();
      test_mid_reset();
`ifdef WB_FWD_EN
      test_fwd();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
